// File: rtl/trivium_pkg.sv
// rtl/trivium_pkg.sv - shared state type and constants for the Trivium loader
package trivium_pkg;

  typedef enum logic [2:0] {
    IDLE,
    KEY_COLLECT,
    KEY_SHIFT,
    INIT_WAIT,
    DATA_IDLE,
    DATA_SHIFT,
    GAP
  } loader_state_t;

  localparam int TRIVIUM_KEY_BITS    = 80;
  localparam int TRIVIUM_INIT_CYCLES = 4 * 288;

endpackage

// File: rtl/trivium_piso.sv
// rtl/trivium_piso.sv - parallel-in/serial-out shift register, MSB first
// A load presents din's MSB on the very next cycle; shifting past the end emits zeros.
module trivium_piso #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_msb
);

  logic [WIDTH-1:0] r_q;
  logic             r_msb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q   <= '0;
      r_msb <= 1'b0;
    end else if (i_load) begin
      r_msb <= i_din[WIDTH-1];
      r_q   <= {i_din[WIDTH-2:0], 1'b0};
    end else if (i_shift) begin
      r_msb <= r_q[WIDTH-1];
      r_q   <= {r_q[WIDTH-2:0], 1'b0};
    end
  end

  assign o_msb = r_msb;

endmodule

// File: rtl/trivium_loader.sv
// rtl/trivium_loader.sv - byte-wide key/payload front end for the Trivium core
// Collects an 80-bit key, serialises it, waits out core warm-up, then serialises payload bytes.
module trivium_loader
  import trivium_pkg::*;
#(
  parameter int KEY_BYTES   = TRIVIUM_KEY_BITS / 8,
  parameter int INIT_CYCLES = TRIVIUM_INIT_CYCLES,
  parameter int GAP_CYCLES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_byte,
  input  logic       in_is_key,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       key,
  output logic       strob_key,
  output logic       data,
  output logic       strob_data,
  output logic       busy,
  output logic       err
);

  localparam int KEY_BITS = KEY_BYTES * 8;
  localparam int BYTE_W   = $clog2(KEY_BYTES + 1);
  localparam int WAIT_W   = $clog2(INIT_CYCLES + 1);

  loader_state_t       r_state, w_next;
  logic [6:0]          r_bit_cnt;
  logic [BYTE_W-1:0]   r_byte_cnt;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [KEY_BITS-1:0] r_key_buf;
  logic                r_strob_key, r_strob_data, r_busy, r_err;
  logic                w_ready, w_key_acc, w_pay_acc, w_last_key;
  logic                w_err, w_load_key, w_load_data, w_shift_key, w_shift_data;
  logic [KEY_BITS-1:0] w_key_word;

  assign w_ready    = (r_state == IDLE) || (r_state == KEY_COLLECT) || (r_state == DATA_IDLE);
  assign in_ready   = w_ready & ~rst;
  assign w_key_acc  = in_valid & in_ready & in_is_key;
  assign w_pay_acc  = in_valid & in_ready & ~in_is_key;
  assign w_last_key = (r_byte_cnt == BYTE_W'(KEY_BYTES - 1));
  assign w_key_word = {r_key_buf[KEY_BITS-9:0], in_byte};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:        if (w_key_acc) w_next = KEY_COLLECT;
      KEY_COLLECT: begin
        if (w_key_acc && w_last_key) w_next = KEY_SHIFT;
        else if (w_pay_acc)          w_next = IDLE;
      end
      KEY_SHIFT:   if (r_bit_cnt == 7'(KEY_BITS - 1)) w_next = INIT_WAIT;
      INIT_WAIT:   if (r_wait_cnt == WAIT_W'(INIT_CYCLES - 1)) w_next = DATA_IDLE;
      DATA_IDLE: begin
        if (w_key_acc)      w_next = KEY_COLLECT;
        else if (w_pay_acc) w_next = DATA_SHIFT;
      end
      DATA_SHIFT:  if (r_bit_cnt == 7'd7) w_next = GAP;
      GAP:         if (r_wait_cnt == WAIT_W'(GAP_CYCLES - 1)) w_next = DATA_IDLE;
      default:     w_next = IDLE;
    endcase
  end

  always_comb begin
    w_err        = w_pay_acc && ((r_state == IDLE) || (r_state == KEY_COLLECT));
    w_load_key   = w_key_acc && (r_state == KEY_COLLECT) && w_last_key;
    w_load_data  = w_pay_acc && (r_state == DATA_IDLE);
    w_shift_key  = (r_state == KEY_SHIFT);
    w_shift_data = (r_state == DATA_SHIFT);
  end

  // A key byte arriving outside KEY_COLLECT always restarts the key at byte 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt  <= '0;
      r_wait_cnt <= '0;
      r_byte_cnt <= '0;
      r_key_buf  <= '0;
    end else begin
      if (r_state != w_next) begin
        r_bit_cnt  <= '0;
        r_wait_cnt <= '0;
      end else begin
        if (w_shift_key || w_shift_data)              r_bit_cnt  <= r_bit_cnt + 7'd1;
        if ((r_state == INIT_WAIT) || (r_state == GAP)) r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end
      if (w_key_acc && (w_next == KEY_COLLECT))
        r_byte_cnt <= (r_state == KEY_COLLECT) ? r_byte_cnt + BYTE_W'(1) : BYTE_W'(1);
      else if (r_state != w_next)
        r_byte_cnt <= '0;
      if (w_key_acc)
        r_key_buf <= (r_state == KEY_COLLECT) ? w_key_word : KEY_BITS'(in_byte);
      else if (w_err)
        r_key_buf <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_strob_key  <= 1'b0;
      r_strob_data <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_strob_key  <= (w_next == KEY_SHIFT);
      r_strob_data <= (w_next == DATA_SHIFT);
      r_busy       <= !((w_next == IDLE) || (w_next == DATA_IDLE));
      r_err        <= w_err;
    end
  end

  trivium_piso #(.WIDTH(KEY_BITS)) u_key_piso (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load_key),
    .i_shift (w_shift_key),
    .i_din   (w_key_word),
    .o_msb   (key)
  );

  trivium_piso #(.WIDTH(8)) u_data_piso (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load_data),
    .i_shift (w_shift_data),
    .i_din   (in_byte),
    .o_msb   (data)
  );

  assign strob_key  = r_strob_key;
  assign strob_data = r_strob_data;
  assign busy       = r_busy;
  assign err        = r_err;

endmodule

// File: tb/tb_trivium_loader.sv
// tb/tb_trivium_loader.sv - scoreboard bench for trivium_loader
module tb_trivium_loader;

  localparam int KEY_BYTES   = 10;
  localparam int INIT_CYCLES = 1152;
  localparam int GAP_CYCLES  = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_byte = 8'h00;
  logic       in_is_key = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready, key, strob_key, data, strob_data, busy, err;

  trivium_loader #(
    .KEY_BYTES   (KEY_BYTES),
    .INIT_CYCLES (INIT_CYCLES),
    .GAP_CYCLES  (GAP_CYCLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_byte    (in_byte),
    .in_is_key  (in_is_key),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .key        (key),
    .strob_key  (strob_key),
    .data       (data),
    .strob_data (strob_data),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  bit         exp_key_q[$];
  bit         exp_data_q[$];
  int         exp_err = 0;
  logic [7:0] kbytes[$];
  int         mode = 0;
  int         key_run = 0, data_run = 0, post_key = -1, post_data = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // mode 0: no key, 1: collecting key bytes, 2: keyed (payload allowed)
  task automatic model_accept(input logic [7:0] b, input bit is_key);
    if (is_key) begin
      if (mode != 1) kbytes.delete();
      kbytes.push_back(b);
      mode = 1;
      if (kbytes.size() == KEY_BYTES) begin
        foreach (kbytes[i])
          for (int j = 7; j >= 0; j--) exp_key_q.push_back(kbytes[i][j]);
        kbytes.delete();
        mode = 2;
      end
    end else if (mode == 2) begin
      for (int j = 7; j >= 0; j--) exp_data_q.push_back(b[j]);
    end else begin
      exp_err++;
      kbytes.delete();
      mode = 0;
    end
  endtask

  task automatic send(input logic [7:0] b, input bit is_key, output bit immediate);
    int n;
    n = 0;
    @(negedge clk);
    in_byte   = b;
    in_is_key = is_key;
    in_valid  = 1'b1;
    immediate = in_ready;
    while (!in_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("send_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    model_accept(b, is_key);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_settled();
    int n;
    n = 0;
    @(negedge clk);
    while (!(in_ready && post_key < 0 && post_data < 0 &&
             exp_key_q.size() == 0 && exp_data_q.size() == 0) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("settle_ready", in_ready, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    exp_key_q.delete();
    exp_data_q.delete();
    kbytes.delete();
    mode = 0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      key_run = 0; data_run = 0; post_key = -1; post_data = -1;
    end else begin
      if (strob_key && strob_data) chk("strobe_overlap", 1, 0);
      if (!strob_key && key)       chk("key_zero_when_idle", key, 0);
      if (!strob_data && data)     chk("data_zero_when_idle", data, 0);
      if (strob_key) begin
        if (exp_key_q.size() == 0) chk("unexpected_key_bit", 1, 0);
        else                       chk("key_bit", key, exp_key_q.pop_front());
        key_run++;
      end else if (key_run > 0) begin
        chk("key_strobe_len", key_run, 80);
        key_run = 0;
        post_key = 0;
      end
      if (strob_data) begin
        if (exp_data_q.size() == 0) chk("unexpected_data_bit", 1, 0);
        else                        chk("data_bit", data, exp_data_q.pop_front());
        data_run++;
      end else if (data_run > 0) begin
        chk("data_strobe_len", data_run, 8);
        data_run = 0;
        post_data = 0;
      end
      if (post_key >= 0) begin
        if (in_ready) begin chk("init_wait_len", post_key, INIT_CYCLES); post_key = -1; end
        else post_key++;
      end
      if (post_data >= 0) begin
        if (in_ready) begin chk("gap_len", post_data, GAP_CYCLES); post_data = -1; end
        else post_data++;
      end
      if (err) begin
        chk("err_expected", exp_err > 0, 1);
        if (exp_err > 0) exp_err--;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit imm;
    int n;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_strob_key", strob_key, 0);
    chk("rst_strob_data", strob_data, 0);
    chk("rst_key", key, 0);
    chk("rst_data", data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_busy", busy, 0);

    for (int i = 0; i < KEY_BYTES; i++) begin
      send(8'(i + 1), 1'b1, imm);
      chk("key_b2b_ready", imm, 1);
    end
    send(8'hA5, 1'b0, imm);
    repeat (6) send(8'($urandom), 1'b0, imm);
    wait_settled();

    do_reset();
    send(8'h3C, 1'b0, imm);
    repeat (4) @(negedge clk);
    chk("idle_err_busy", busy, 0);
    chk("idle_err_ready", in_ready, 1);

    repeat (4) send(8'($urandom), 1'b1, imm);
    send(8'hFF, 1'b0, imm);
    repeat (KEY_BYTES) send(8'($urandom), 1'b1, imm);
    repeat (3) send(8'($urandom), 1'b0, imm);

    send(8'h80, 1'b1, imm);
    repeat (KEY_BYTES - 1) send(8'($urandom), 1'b1, imm);
    repeat (2) send(8'($urandom), 1'b0, imm);

    repeat (12) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(8'($urandom), 1'b0, imm);
    end
    wait_settled();

    repeat (KEY_BYTES) send(8'($urandom), 1'b1, imm);
    n = 0;
    @(negedge clk);
    while (!strob_key && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("key_shift_start", strob_key, 1);
    repeat (39) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_strob_key", strob_key, 0);
    chk("async_rst_key", key, 0);
    chk("async_rst_ready", in_ready, 0);
    chk("async_rst_busy", busy, 0);
    exp_key_q.delete();
    kbytes.delete();
    mode = 0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_busy", busy, 0);

    send(8'($urandom), 1'b0, imm);
    repeat (20) @(negedge clk);

    chk("key_queue_empty", exp_key_q.size(), 0);
    chk("data_queue_empty", exp_data_q.size(), 0);
    chk("err_all_seen", exp_err, 0);
    chk("no_pending_init", post_key, -1);
    chk("no_pending_gap", post_data, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trivium_loader.md
# trivium_loader

Byte-wide front end for the Trivium cipher core. Accepts key and payload bytes over a valid/ready handshake, serialises the 80-bit key MSB-first onto `key`/`strob_key`, waits out the core's initialisation, then serialises each payload byte onto `data`/`strob_data` with a fixed inter-byte gap. It sits directly upstream of the cipher core and drives its serial inputs.

## Interface
- `KEY_BYTES`, 10: key length in bytes (80 bits).
- `INIT_CYCLES`, 1152: idle cycles after the last key bit, covering core warm-up.
- `GAP_CYCLES`, 2: idle cycles after each payload byte, covering the core's output stages.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous reset, active-high.
- `in_byte`  in  8  key or payload byte.
- `in_is_key`  in  1  1 = `in_byte` is a key byte; 0 = payload.
- `in_valid`  in  1  `in_byte` valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `key`  out  1  serial key bit.
- `strob_key`  out  1  `key` is valid.
- `data`  out  1  serial payload bit.
- `strob_data`  out  1  `data` is valid.
- `busy`  out  1  state is not IDLE or DATA_IDLE.
- `err`  out  1  one-cycle pulse on a protocol violation.

## Operation
- Accept rule: a byte transfers on a rising edge where `in_valid & in_ready`.
- `in_ready` is decoded from state: 1 in IDLE, KEY_COLLECT and DATA_IDLE; 0 elsewhere; forced 0 while `rst` is high.
- IDLE
  - Key byte: store as byte 0, set byte count to 1, go to KEY_COLLECT.
  - Payload byte: discard it, pulse `err`, stay in IDLE.
- KEY_COLLECT
  - Key byte: store it and increment the count.
  - On the KEY_BYTES-th byte: go to KEY_SHIFT.
  - Payload byte: discard the partial key, pulse `err`, go to IDLE.
- KEY_SHIFT: for 80 cycles, `strob_key`=1 and `key` carries the bits in order byte0 bit7, byte0 bit6, … byte9 bit0. Then go to INIT_WAIT.
- INIT_WAIT: all strobes 0 for INIT_CYCLES cycles, then go to DATA_IDLE.
- DATA_IDLE
  - Payload byte: go to DATA_SHIFT.
  - Key byte: rekey. The byte becomes key byte 0 (count=1), go to KEY_COLLECT. No `err`.
- DATA_SHIFT: for 8 cycles, `strob_data`=1 and `data` carries bit7 first. Then go to GAP.
- GAP: strobes 0 for GAP_CYCLES cycles, then go to DATA_IDLE.
- `key` and `data` are 0 whenever their strobe is 0. `strob_key` and `strob_data` are never high together.
- Counters:
  - Bit counter: 7 bits, range 0..79.
  - Byte counter: $clog2(KEY_BYTES+1) bits.
  - Wait counter: $clog2(INIT_CYCLES+1) bits, shared by INIT_WAIT and GAP.
  - All counters clear on every state entry. No wrap beyond terminal count.

## Timing
- All outputs except `in_ready` are registered.
- Reset values: state IDLE; `key`, `strob_key`, `data`, `strob_data`, `busy`, `err` = 0; all counters and buffers = 0.
- Last key byte accepted at edge T: `strob_key` is high in cycles T+1..T+80.
- INIT_WAIT: cycles T+81..T+80+INIT_CYCLES. `in_ready` goes to 1 in cycle T+81+INIT_CYCLES.
- Payload byte accepted at edge P: `strob_data` is high in cycles P+1..P+8. GAP covers P+9..P+8+GAP_CYCLES. `in_ready`=1 again in P+9+GAP_CYCLES.
- Sustained payload throughput: one byte per 9+GAP_CYCLES cycles.
- `err` is high for exactly the one cycle following the offending edge.
- `rst` asserted in any state: outputs drop to reset values immediately (asynchronously). A partially shifted key or byte is lost. After release, the loader restarts at IDLE and requires a full key.

## Structure
- Package `trivium_pkg`:
  - state enum `loader_state_t` (IDLE, KEY_COLLECT, KEY_SHIFT, INIT_WAIT, DATA_IDLE, DATA_SHIFT, GAP);
  - constant `TRIVIUM_KEY_BITS` = 80;
  - constant `TRIVIUM_INIT_CYCLES` = 1152 (4×288).
- Sub-module `trivium_piso`: parameterised-width parallel-in/serial-out shift register with load, shift and MSB output. Instantiated twice: 80-bit key, 8-bit payload.

## Test plan
- Reset, then 10 key bytes 0x01..0x0A back-to-back → `in_ready`=1 for all 10. `strob_key` high for exactly 80 cycles. First 8 `key` bits are 0,0,0,0,0,0,0,1; last 8 are 0,0,0,0,1,0,1,0.
- After the key (INIT_CYCLES=1152), drive payload 0xA5 as soon as possible → `in_ready` rises exactly 1152 cycles after the last `strob_key`. `data` = 1,0,1,0,0,1,0,1 under `strob_data`. `in_ready` returns after 2 gap cycles.
- Payload 0x3C in IDLE → `err` pulses for 1 cycle, no strobes, state stays IDLE.
- 4 key bytes, then payload 0xFF → `err` pulse. A following full 10-byte key shifts normally, with no stale bits from the first 4.
- In DATA_IDLE, send key byte 0x80 plus 9 further bytes → no `err`. The new key shifts out with first bit 1, followed by a full INIT_WAIT.
- Assert `rst` at bit 40 of KEY_SHIFT → `strob_key`=0 immediately. After release, `in_ready`=1 and `busy`=0.
